// File: rtl/stream_demux_n.sv
// Registered 1-to-N stream demultiplexer with valid/ready flow control.
// Beats are steered by an explicit select or by a round-robin pointer.
module stream_demux_n #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_mode,
    input  logic                    i_in_valid,
    output logic                    o_in_ready,
    input  logic [WIDTH-1:0]        i_in_data,
    input  logic [SEL_W-1:0]        i_in_sel,
    output logic [NUM_CH-1:0]       o_out_valid,
    input  logic [NUM_CH-1:0]       i_out_ready,
    output logic [NUM_CH*WIDTH-1:0] o_out_data,
    output logic [SEL_W-1:0]        o_rr_ptr,
    output logic                    o_sel_err
);

    logic [NUM_CH-1:0] r_valid;
    logic [WIDTH-1:0]  r_data [NUM_CH];
    logic [SEL_W-1:0]  r_rr_ptr;
    logic              r_sel_err;

    logic [SEL_W-1:0]  w_target;
    logic              w_in_range;
    logic [NUM_CH-1:0] w_free;
    logic              w_target_free;
    logic              w_accept;

    assign w_target   = i_mode ? r_rr_ptr : i_in_sel;
    assign w_in_range = ({1'b0, w_target} < (SEL_W+1)'(NUM_CH));
    assign w_free     = ~r_valid | i_out_ready;

    // Out-of-range targets match no channel and so default to ready (discard).
    always_comb begin
        w_target_free = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_target == SEL_W'(c)) begin
                w_target_free = w_free[c];
            end
        end
    end

    assign o_in_ready = w_target_free;
    assign w_accept   = i_in_valid && w_target_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_data[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_accept && w_in_range && (w_target == SEL_W'(c))) begin
                    r_valid[c] <= 1'b1;
                    r_data[c]  <= i_in_data;
                end else if (i_out_ready[c]) begin
                    r_valid[c] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr  <= '0;
            r_sel_err <= 1'b0;
        end else begin
            if (w_accept && i_mode) begin
                r_rr_ptr <= (r_rr_ptr == SEL_W'(NUM_CH-1)) ? '0 : r_rr_ptr + SEL_W'(1);
            end
            if (w_accept && !w_in_range) begin
                r_sel_err <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign o_out_data[g*WIDTH +: WIDTH] = r_data[g];
    end

    assign o_out_valid = r_valid;
    assign o_rr_ptr    = r_rr_ptr;
    assign o_sel_err   = r_sel_err;

endmodule

// File: tb/tb_stream_demux_n.sv
// Bench for stream_demux_n with five channels, so out-of-range selects exist.
// A per-channel slot model predicts ready, outputs, pointer and error flag.
module tb_stream_demux_n;

    localparam int W   = 8;
    localparam int NCH = 5;
    localparam int SW  = $clog2(NCH);

    logic              clk;
    logic              rst_n;
    logic              mode;
    logic              inValid;
    logic              inReady;
    logic [W-1:0]      inData;
    logic [SW-1:0]     inSel;
    logic [NCH-1:0]    outValid;
    logic [NCH-1:0]    outReady;
    logic [NCH*W-1:0]  outData;
    logic [SW-1:0]     rrPtr;
    logic              selErr;

    int compareCount  = 0;
    int mismatchCount = 0;

    bit         mValid [NCH];
    logic [7:0] mData  [NCH];
    int         mRr;
    bit         mErr;

    stream_demux_n #(.WIDTH(W), .NUM_CH(NCH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_mode      (mode),
        .i_in_valid  (inValid),
        .o_in_ready  (inReady),
        .i_in_data   (inData),
        .i_in_sel    (inSel),
        .o_out_valid (outValid),
        .i_out_ready (outReady),
        .o_out_data  (outData),
        .o_rr_ptr    (rrPtr),
        .o_sel_err   (selErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compareCount++;
        assert (obs === exp) else begin
            mismatchCount++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelClear();
        for (int c = 0; c < NCH; c++) begin
            mValid[c] = 1'b0;
            mData[c]  = 8'h00;
        end
        mRr  = 0;
        mErr = 1'b0;
    endtask

    function automatic bit expReady(input bit m, input int sel, input logic [NCH-1:0] rdy);
        int t;
        t = m ? mRr : sel;
        if (t >= NCH) return 1'b1;
        return !mValid[t] || rdy[t];
    endfunction

    task automatic checkOutput(input string tag);
        logic [NCH-1:0]   ev;
        logic [NCH*W-1:0] ed;
        for (int c = 0; c < NCH; c++) begin
            ev[c]          = mValid[c];
            ed[c*W +: W]   = mData[c];
        end
        cmp({tag, ".valid"}, 64'(outValid), 64'(ev));
        cmp({tag, ".data"},  64'(outData),  64'(ed));
        cmp({tag, ".rr"},    64'(rrPtr),    64'(mRr));
        cmp({tag, ".err"},   64'(selErr),   64'(mErr));
    endtask

    // Drive one cycle, check ready before the edge, advance the model, check outputs after.
    task automatic applyStimulus(input bit m, input bit v, input logic [7:0] d,
                                 input int sel, input logic [NCH-1:0] rdy, input string tag);
        bit acc;
        int t;
        @(negedge clk);
        mode     = m;
        inValid  = v;
        inData   = d;
        inSel    = SW'(sel);
        outReady = rdy;
        #1;
        cmp({tag, ".ready"}, 64'(inReady), 64'(expReady(m, sel, rdy)));
        @(posedge clk);
        t   = m ? mRr : sel;
        acc = v && expReady(m, sel, rdy);
        for (int c = 0; c < NCH; c++) begin
            if (mValid[c] && rdy[c]) mValid[c] = 1'b0;
        end
        if (acc) begin
            if (t < NCH) begin
                mValid[t] = 1'b1;
                mData[t]  = d;
            end else begin
                mErr = 1'b1;
            end
            if (m) mRr = (mRr + 1) % NCH;
        end
        #1;
        checkOutput(tag);
    endtask

    task automatic idleInputs();
        mode     = 1'b0;
        inValid  = 1'b0;
        inData   = '0;
        inSel    = '0;
        outReady = '1;
    endtask

    initial begin
        idleInputs();
        modelClear();
        rst_n = 1'b0;
        #12;
        checkOutput("reset");
        cmp("reset.ready", 64'(inReady), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Explicit select, everything ready
        applyStimulus(0, 1, 8'hA0, 3, 5'h1F, "sel0");
        applyStimulus(0, 1, 8'hA1, 0, 5'h1F, "sel1");
        applyStimulus(0, 1, 8'hA2, 2, 5'h1F, "sel2");
        applyStimulus(0, 1, 8'hA3, 1, 5'h1F, "sel3");
        applyStimulus(0, 0, 8'h00, 0, 5'h1F, "selIdle");

        // Back-pressure on channel 1 only
        applyStimulus(0, 1, 8'h11, 1, 5'h1D, "bp11");
        applyStimulus(0, 1, 8'h22, 1, 5'h1D, "bp22stall");
        applyStimulus(0, 1, 8'h33, 0, 5'h1D, "bpOther");
        applyStimulus(0, 1, 8'h22, 1, 5'h1F, "bp22go");
        applyStimulus(0, 0, 8'h00, 0, 5'h1F, "bpDrain");

        // Round-robin with all ready, then a stall on channel 2
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 1, 8'(i), 0, 5'h1F, $sformatf("rr%0d", i));
        end
        cmp("rrAfterSix", 64'(rrPtr), 64'd1);
        applyStimulus(1, 1, 8'h06, 0, 5'h1F, "rr6");
        applyStimulus(0, 1, 8'h62, 2, 5'h1B, "rrFill2");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 8'h07, 0, 5'h1B, $sformatf("rrStall%0d", i));
        end
        applyStimulus(1, 1, 8'h07, 0, 5'h1F, "rrRelease");

        // Out-of-range selects are discarded and latch the error flag
        applyStimulus(0, 1, 8'h5A, 5, 5'h00, "oor5");
        applyStimulus(0, 1, 8'h5B, 7, 5'h00, "oor7");
        applyStimulus(0, 1, 8'h5C, 4, 5'h1F, "oorValid");

        // Drain and load of the same channel in one cycle
        applyStimulus(0, 1, 8'h66, 0, 5'h1E, "dl66");
        applyStimulus(0, 1, 8'h77, 0, 5'h1F, "dl77");
        cmp("dlHold", 64'(outData[7:0]), 64'h77);

        // Asynchronous reset with channel 2 holding data
        applyStimulus(0, 1, 8'h99, 2, 5'h1B, "preRst");
        idleInputs();
        #1;
        rst_n = 1'b0;
        #1;
        modelClear();
        checkOutput("midRst");
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 1, 8'h42, 2, 5'h1B, "postRst");

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7),
                          8'($urandom), int'($urandom_range(0, 7)),
                          NCH'($urandom), $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/stream_demux_n.md
# stream_demux_n

Parametrised, registered 1-to-N streaming demultiplexer with valid/ready flow control. Each accepted input beat is steered to one of NUM_CH output channels, chosen either by an explicit select or by an internal round-robin pointer. Every channel has a one-entry output register, so a stalled channel back-pressures only beats addressed to it. It sits between a single producer and NUM_CH independent consumers. It replaces the fixed 1x4, 1-bit combinational demux wherever width, channel count or back-pressure are needed.

## Interface
- WIDTH, 8, data bits per beat (>=1)
- NUM_CH, 4, number of output channels (2..16; need not be a power of 2)
- SEL_W, $clog2(NUM_CH), select/pointer width (derived; do not override)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- mode  in  1  0 = explicit select (in_sel), 1 = round-robin (rr_ptr)
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_data  in  WIDTH  input payload
- in_sel  in  SEL_W  target channel in mode 0; ignored in mode 1
- out_valid  out  NUM_CH  per-channel valid; bit c = channel c
- out_ready  in  NUM_CH  per-channel ready
- out_data  out  NUM_CH*WIDTH  channel c at bits [c*WIDTH +: WIDTH]
- rr_ptr  out  SEL_W  current round-robin pointer
- sel_err  out  1  sticky: an out-of-range in_sel beat was accepted

## Operation
- Target channel t: mode 0 gives t = in_sel; mode 1 gives t = rr_ptr. mode is sampled per beat and may change between any two beats.
- Channel c is free when !out_valid[c] || out_ready[c].
- in_ready = free(t) when t < NUM_CH. When t >= NUM_CH (mode 0 only, non-power-of-2 NUM_CH), in_ready = 1.
- Accept with t valid: out_data[t] <= in_data and out_valid[t] <= 1 at the next edge.
- Accept with t out of range: the beat is discarded, no channel changes, and sel_err <= 1. sel_err clears only on reset.
- Channel c drains when out_valid[c] && out_ready[c]. out_valid[c] <= 0 unless the same cycle loads a new beat into c, in which case it stays 1 with the new data (back-to-back).
- Round-robin pointer: advances only on an accepted beat in mode 1. It steps rr_ptr <= rr_ptr+1 and wraps NUM_CH-1 -> 0. It does not advance in mode 0 or on a stalled cycle.
- rr_ptr sequence (state): 0 -> 1 -> ... -> NUM_CH-1 -> 0. No other states are reachable.
- Holding rule: while out_valid[c] && !out_ready[c], out_data[c] and out_valid[c] are stable.
- Only one channel is loaded per cycle. Any number of channels may drain in the same cycle.
- out_data of a channel holds its last value after it drains.
- Reset (any time, including mid-transfer): out_valid = 0, out_data = 0, rr_ptr = 0, sel_err = 0. An in-flight beat is lost. in_ready follows combinationally from reset state, so it is 1 for any in-range target.

## Timing
- Latency: 1 cycle. A beat accepted at edge k is visible on out_valid/out_data after edge k.
- Throughput: 1 beat/cycle when the target channel is free. In mode 1, all channels draining gives 1 beat/cycle indefinitely.
- in_ready is combinational from mode, in_sel, rr_ptr, out_valid and out_ready; there is no path from in_valid.
- in_valid is not required to hold; the producer may withdraw or change a beat while in_ready = 0. Consumers must not depend on out_ready -> out_valid combinationally (there is no such path).
- All state updates on the rising clk edge. Async assert of rst_n, synchronous deassert is the integrator's responsibility.

## Test plan
- Reset: assert rst_n=0 mid-stream with channel 2 holding data -> out_valid=0, out_data=0, rr_ptr=0, sel_err=0 immediately. After release, a beat with in_sel=2 is accepted.
- Explicit select, NUM_CH=4, all out_ready=1: beats 0xA0..0xA3 with in_sel 3,0,2,1 -> one cycle later each appears on the matching channel only. in_ready=1 throughout, rr_ptr stays 0.
- Back-pressure: out_ready[1]=0, send 0x11 then 0x22 to channel 1 -> 0x11 held and in_ready=0 for 0x22. A beat to channel 0 is still accepted. Raising out_ready[1] accepts 0x22 the same cycle and out_data[1]=0x22 next cycle.
- Round-robin, mode=1: 6 beats 0..5 with all ready -> channels 0,1,2,3,0,1 and rr_ptr=2 at the end. Stall channel 2 for 3 cycles -> rr_ptr holds at 2 and no beat is lost or skipped.
- Out-of-range, NUM_CH=3, mode 0: in_sel=3 with data 0x5A -> in_ready=1, no out_valid rises, sel_err=1 and stays 1 through later valid traffic.
- Simultaneous drain+load: channel 0 full with out_ready[0]=1 while a new beat 0x77 is accepted for channel 0 -> out_valid[0] stays 1 and out_data[0]=0x77 next cycle.
